// File: rtl/store_unit_pkg.sv
// Shared types for the store path: access sizes, FSM states, word geometry,
// and the per-size byte mask used by the lane aligner.
package store_unit_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MEM_SIZE__BYTE    = 2'b00,
    MEM_SIZE__HALF    = 2'b01,
    MEM_SIZE__WORD    = 2'b10,
    MEM_SIZE__ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    STORE__IDLE,
    STORE__WR_LO,
    STORE__WR_HI,
    STORE__DONE
  } store_state_t;

  // Bytes touched by an access, right-aligned; illegal size touches nothing.
  function automatic logic [WORD_BYTES-1:0] size_mask(mem_size_t size);
    case (size)
      MEM_SIZE__BYTE: size_mask = 4'b0001;
      MEM_SIZE__HALF: size_mask = 4'b0011;
      MEM_SIZE__WORD: size_mask = 4'b1111;
      default:        size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request and memory write-port bundle for store_unit. The master modport is
// the store unit's view; slave is the core/memory side.
interface store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    input  req_valid, req_addr, req_data, req_size, mem_ack,
    output req_ready, done, err, mem_addr, mem_wdata, mem_be, mem_we
  );

  modport slave (
    output req_valid, req_addr, req_data, req_size, mem_ack,
    input  req_ready, done, err, mem_addr, mem_wdata, mem_be, mem_we
  );
endinterface

// File: rtl/store_unit_lane_align.sv
// Combinational byte-lane aligner: places a right-aligned store value into a
// two-word window starting at the byte offset. Also used by the load path.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  mem_size_t   size,
  input  logic [31:0] data,
  output logic [7:0]  be8,
  output logic [63:0] d64,
  output logic        needs_hi,
  output logic        misaligned
);

  logic [31:0] data_m;

  // Mask off bytes above the access size so disabled lanes carry zero.
  always_comb begin
    data_m = '0;
    case (size)
      MEM_SIZE__BYTE: data_m = {24'b0, data[7:0]};
      MEM_SIZE__HALF: data_m = {16'b0, data[15:0]};
      MEM_SIZE__WORD: data_m = data;
      default:        data_m = '0;
    endcase
    be8        = {4'b0000, size_mask(size)} << off;
    d64        = {32'b0, data_m} << {off, 3'b000};
    needs_hi   = |be8[7:4];
    misaligned = ((size == MEM_SIZE__HALF) && (off == 2'd3)) ||
                 ((size == MEM_SIZE__WORD) && (off != 2'd0));
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: turns sb/sh/sw requests into one or two aligned word writes
// with byte enables, then pulses done (with err for rejected stores).
// Optional build macro STORE_MISALIGN_TRAP_EN: word-crossing half/word stores
// are rejected with err instead of being split into two beats.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  store_unit_if.master bus
);

  store_state_t state;
  mem_size_t    size_in;
  logic [7:0]   be8;
  logic [63:0]  d64;
  logic         needs_hi;
  logic         misaligned;
  logic         trap;
  logic         needs_hi_q;
  logic [3:0]   hi_be;
  logic [31:0]  hi_wdata;

  assign size_in = mem_size_t'(bus.req_size);

  store_lane_align u_align (
    .off        (bus.req_addr[1:0]),
    .size       (size_in),
    .data       (bus.req_data),
    .be8        (be8),
    .d64        (d64),
    .needs_hi   (needs_hi),
    .misaligned (misaligned)
  );

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  // Misaligned stores are split into two beats rather than rejected.
  assign trap = misaligned & 1'b0;
`endif

  // Store sequencer; all bus outputs are registered and held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STORE__IDLE;
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      needs_hi_q    <= 1'b0;
      hi_be         <= '0;
      hi_wdata      <= '0;
    end else begin
      case (state)
        STORE__IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            if ((size_in == MEM_SIZE__ILLEGAL) || trap) begin
              state    <= STORE__DONE;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else begin
              state         <= STORE__WR_LO;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_be    <= be8[3:0];
              bus.mem_wdata <= d64[31:0];
              needs_hi_q    <= needs_hi;
              hi_be         <= be8[7:4];
              hi_wdata      <= d64[63:32];
            end
          end
        end
        STORE__WR_LO: begin
          if (bus.mem_ack) begin
            if (needs_hi_q) begin
              state         <= STORE__WR_HI;
              bus.mem_addr  <= bus.mem_addr + ADDR_W'(WORD_BYTES);
              bus.mem_be    <= hi_be;
              bus.mem_wdata <= hi_wdata;
            end else begin
              state         <= STORE__DONE;
              bus.done      <= 1'b1;
              bus.err       <= 1'b0;
              bus.mem_we    <= 1'b0;
              bus.mem_be    <= '0;
              bus.mem_wdata <= '0;
            end
          end
        end
        STORE__WR_HI: begin
          if (bus.mem_ack) begin
            state         <= STORE__DONE;
            bus.done      <= 1'b1;
            bus.err       <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
          end
        end
        default: begin
          state         <= STORE__IDLE;
          bus.done      <= 1'b0;
          bus.err       <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
Write-side master for the unified instruction/data memory. It turns a core store request (sb/sh/sw) into one or two aligned word-wide writes with byte enables. It sits between the control FSM/datapath and the memory's write port, which is driven today with constant write-disable and no data. Misaligned stores that cross a word boundary are split into two beats, and the store completes with a one-cycle done pulse.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, memory word width; only 32 is supported

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  store request valid
req_ready  out  1  unit idle; accepts a request this cycle
req_addr  in  32  byte address of the store
req_data  in  32  store data (rs2), right-aligned
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0])
done  out  1  one-cycle pulse when the store is finished
err  out  1  valid with done; store rejected, no memory write issued
mem_addr  out  32  word-aligned write address (low 2 bits always 00)
mem_wdata  out  32  lane-aligned write data
mem_be  out  4  byte enables; bit i covers mem_wdata[8i+7:8i]
mem_we  out  1  write strobe, held until acknowledged
mem_ack  in  1  memory accepted the current write (may be high in the same cycle as mem_we)

Behaviour:
- Reset values: req_ready=1, done=0, err=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. State is IDLE.
- States and transitions:
  - IDLE: req_ready=1.
    - On req_valid, latch addr/data/size.
    - If size is legal, go to WR_LO.
    - If req_size=11, go to DONE with err=1.
  - WR_LO: drive the low beat with mem_we=1.
    - On mem_ack with a high beat needed, go to WR_HI.
    - On mem_ack with no high beat, go to DONE.
    - Without mem_ack, hold and keep all mem_* outputs stable.
  - WR_HI: drive the high beat with mem_we=1. On mem_ack, go to DONE.
  - DONE: done=1 and err as latched for one cycle, req_ready=0. Then return to IDLE.
- Lane math (off = addr[1:0]):
  - mask = 0001 for byte, 0011 for half, 1111 for word.
  - be8[7:0] = mask << off.
  - d64[63:0] = zero-extended data << (8*off).
- Low beat: mem_addr = {addr[31:2],00}, mem_be = be8[3:0], mem_wdata = d64[31:0].
- High beat: needed iff be8[7:4] != 0. mem_addr = low address + 4, wrapping modulo 2^32 (0xFFFFFFFC goes to 0x00000000). mem_be = be8[7:4], mem_wdata = d64[63:32].
- Disabled byte lanes of mem_wdata are driven 0.
- mem_we=0 in IDLE and DONE. mem_be=0 whenever mem_we=0.
- Latency with mem_ack tied high:
  - Aligned store: accept at cycle 0, write at cycle 1, done at cycle 2, req_ready at cycle 3.
  - Split store: adds 1 cycle.
- req_valid while not in IDLE is ignored. The request is not latched and the requester must hold it.
- mem_ack outside WR_LO/WR_HI is ignored.
- Reset mid-operation: return to IDLE next cycle and drop mem_we. A beat already acknowledged stays written; no rollback. done is not pulsed.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: a half store with off=3, or a word store with off!=0, goes IDLE to DONE with err=1 and issues no memory write. WR_HI is never entered.
- Undefined: these stores are split into two beats as described above. err is raised only for size 11.

Decomposition:
- Shared types package:
  - mem_size_t: MEM_SIZE__BYTE, MEM_SIZE__HALF, MEM_SIZE__WORD, MEM_SIZE__ILLEGAL.
  - store_state_t: STORE__IDLE, STORE__WR_LO, STORE__WR_HI, STORE__DONE.
  - Constant WORD_BYTES=4.
- One combinational sub-module, store_lane_align.
  - Inputs: off, size, data.
  - Outputs: be8, d64, needs_hi, misaligned.
  - Reused later by the load-extract path.

Test Plan:
- sw 0xDEADBEEF to 0x100, ack tied high -> cycle 1: mem_addr=0x100, be=1111, wdata=0xDEADBEEF. Cycle 2: done=1, err=0.
- sb 0x000000A5 to 0x203 -> single beat: mem_addr=0x200, be=1000, wdata=0xA5000000.
- sh 0x0000BEEF to 0x303, macro undefined -> beat 1: 0x300, be=1000, wdata=0xEF000000. Beat 2: 0x304, be=0001, wdata=0x000000BE. Then done.
- sw 0x11223344 to 0xFFFFFFFE, macro undefined -> beat 1: 0xFFFFFFFC, be=1100, wdata=0x33440000. Beat 2: 0x00000000, be=0011, wdata=0x00001122.
- mem_ack low for 3 cycles during WR_LO -> mem_addr/wdata/be/we held stable. done arrives 1 cycle after ack. A req_valid presented meanwhile is not accepted.
- req_size=11 -> mem_we never asserted, done=1 and err=1 at cycle 1.
- With STORE_MISALIGN_TRAP_EN: sw to 0x102 -> no write, done=1 and err=1.
- Reset asserted in WR_HI -> next cycle mem_we=0 and req_ready=1, no done pulse.
